// File: rtl/seg_pkg.sv
// seg_pkg: definitions shared by the 7-segment scan scheduler.
//   FRAME_W  width of one shifted {digit-select, segment} frame
//   NDIG     digits on the display chain
//   SEG_HEX  hex-to-segment map, active-low, bit order a..g,dp (MSB = a)
//   state_t  scan FSM states
package seg_pkg;

  localparam int FRAME_W = 16;
  localparam int NDIG    = 8;
  localparam int DIG_W   = $clog2(NDIG);

  localparam logic [7:0] SEG_HEX [0:15] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Segment pattern for one hex nibble.
  function automatic logic [7:0] seg_hex(input logic [3:0] nib);
    seg_hex = SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/seg_scan_sched_if.sv
// seg_scan_sched_if: source side and display side of the scan scheduler.
//   src_data  NSRC packed 32-bit words, source i at [32i+31:32i]
//   src_valid per-source valid
//   key_n     raw active-low select key
//   blank     force all segments off
//   ds/shclk/stclk  serial data, shift clock and store clock to the 595 chain
//   sel       currently selected source
//   busy      high while a frame is being shifted or latched
// master = sources/key/display consumer, slave = scheduler.
interface seg_scan_sched_if #(
  parameter int NSRC = 4
);
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC*32-1:0] src_data;
  logic [NSRC-1:0]    src_valid;
  logic               key_n;
  logic               blank;
  logic               ds;
  logic               shclk;
  logic               stclk;
  logic [SEL_W-1:0]   sel;
  logic               busy;

  modport master (
    output src_data, src_valid, key_n, blank,
    input  ds, shclk, stclk, sel, busy
  );

  modport slave (
    input  src_data, src_valid, key_n, blank,
    output ds, shclk, stclk, sel, busy
  );

endinterface

// File: rtl/seg_scan_sched_key_debounce.sv
// key_debounce: 2-FF synchronizer and stability filter for the select key.
//   clk, rst_n  clock and asynchronous active-low reset
//   key_n       raw asynchronous active-low key
//   press       one-cycle pulse on each debounced 1->0 transition
// The debounced level only moves after DEB consecutive synchronized samples
// that all disagree with it; any agreeing sample restarts the count.
module key_debounce #(
  parameter int DEB = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-stage synchronizer; idles high like a released key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter, debounced level and press pulse.
  // cnt_r never exceeds CNT_LAST: it is cleared on reaching it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b1;
      cnt_r   <= {CNT_W{1'b0}};
      press_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= {CNT_W{1'b0}};
      press_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      level_r <= sync2_r;
      cnt_r   <= {CNT_W{1'b0}};
      press_r <= ~sync2_r;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
      press_r <= 1'b0;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/seg_scan_sched.sv
// seg_scan_sched: shares one 8-digit 7-segment 595 chain among NSRC sources.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         seg_scan_sched_if slave: source words/valids, key, blank in;
//               ds, shclk, stclk, sel, busy out
// Each frame is LOAD (1) + SHIFT (16 bits x 2*DIV) + LATCH (DIV) + GAP cycles.
// The selected word is captured only at digit 0 so a round is coherent.
// All outputs are registers loaded from the next-state decode, so they line
// up exactly with the state they belong to.
import seg_pkg::*;

module seg_scan_sched #(
  parameter int NSRC = 4,
  parameter int DIV  = 4,
  parameter int GAP  = 256,
  parameter int DEB  = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_sched_if.slave  bus
);

  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int PH_W  = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [PH_W-1:0]  PH_SHIFT_LAST = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH       = PH_W'(DIV);
  localparam logic [PH_W-1:0]  PH_LATCH_LAST = PH_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST      = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t             state_r, state_n;
  logic [DIG_W-1:0]   digit_r, digit_n;
  logic [3:0]         bit_r, bit_n;
  logic [PH_W-1:0]    phase_r, phase_n;
  logic [GAP_W-1:0]   gap_r, gap_n;
  logic [31:0]        shadow_r, shadow_n;
  logic               vld_r, vld_n;
  logic [FRAME_W-1:0] frame_r, frame_n;
  logic               ds_r, ds_n;
  logic               shclk_r, shclk_n;
  logic               stclk_r, stclk_n;
  logic               busy_r, busy_n;
  logic [SEL_W-1:0]   sel_r;

  logic               press_s;
  logic [31:0]        word_s;
  logic               word_vld_s;
  logic [31:0]        load_word_s;
  logic               load_vld_s;
  logic [3:0]         nib_s;
  logic [7:0]         seg_s;
  logic [FRAME_W-1:0] frame_s;

  key_debounce #(
    .DEB (DEB)
  ) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_n),
    .press (press_s)
  );

  // First valid source after cur (wrapping); cur itself if none other is valid.
  function automatic logic [SEL_W-1:0] next_valid_sel(input logic [SEL_W-1:0] cur,
                                                      input logic [NSRC-1:0]  vld);
    logic [SEL_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = cur;
    found = 1'b0;
    for (int k = 1; k < NSRC; k++) begin
      idx = (int'(cur) + k) % NSRC;
      if (!found && vld[idx]) begin
        pick  = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Source selection: advance on each debounced press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= {SEL_W{1'b0}};
    end else if (press_s) begin
      sel_r <= next_valid_sel(sel_r, bus.src_valid);
    end else begin
      sel_r <= sel_r;
    end
  end

  // Frame build: digit 0 uses the live source word, later digits the shadow.
  always_comb begin
    word_s      = bus.src_data[{sel_r, 5'b00000} +: 32];
    word_vld_s  = bus.src_valid[sel_r];
    load_word_s = (digit_r == {DIG_W{1'b0}}) ? word_s : shadow_r;
    load_vld_s  = (digit_r == {DIG_W{1'b0}}) ? word_vld_s : vld_r;
    // digit 0 shows the top nibble, digit 7 the bottom one
    nib_s       = load_word_s[{DIG_W'(NDIG - 1) - digit_r, 2'b00} +: 4];
    seg_s       = (bus.blank || !load_vld_s) ? 8'hFF : seg_hex(nib_s);
    frame_s     = {8'h80 >> digit_r, seg_s};
  end

  // Scan FSM next-state and next-output decode.
  always_comb begin
    state_n  = state_r;
    digit_n  = digit_r;
    bit_n    = bit_r;
    phase_n  = phase_r;
    gap_n    = gap_r;
    shadow_n = shadow_r;
    vld_n    = vld_r;
    frame_n  = frame_r;
    ds_n     = ds_r;
    shclk_n  = 1'b0;
    stclk_n  = 1'b0;
    busy_n   = 1'b0;
    case (state_r)
      ST_LOAD: begin
        shadow_n = load_word_s;
        vld_n    = load_vld_s;
        frame_n  = frame_s;
        bit_n    = 4'd15;
        phase_n  = {PH_W{1'b0}};
        ds_n     = frame_s[FRAME_W-1];
        busy_n   = 1'b1;
        state_n  = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy_n = 1'b1;
        if (phase_r == PH_SHIFT_LAST) begin
          phase_n = {PH_W{1'b0}};
          if (bit_r == 4'd0) begin
            stclk_n = 1'b1;
            state_n = ST_LATCH;
          end else begin
            bit_n = bit_r - 4'd1;
            ds_n  = frame_r[bit_r - 4'd1];
          end
        end else begin
          phase_n = phase_r + PH_W'(1);
          // second half of each bit drives shclk high
          shclk_n = ((phase_r + PH_W'(1)) >= PH_HIGH);
        end
      end
      ST_LATCH: begin
        if (phase_r == PH_LATCH_LAST) begin
          phase_n = {PH_W{1'b0}};
          gap_n   = {GAP_W{1'b0}};
          if (GAP == 0) begin
            digit_n = digit_r + DIG_W'(1);
            state_n = ST_LOAD;
          end else begin
            state_n = ST_GAP;
          end
        end else begin
          phase_n = phase_r + PH_W'(1);
          stclk_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          gap_n   = {GAP_W{1'b0}};
          digit_n = digit_r + DIG_W'(1);
          state_n = ST_LOAD;
        end else begin
          gap_n = gap_r + GAP_W'(1);
        end
      end
      default: begin
        state_n = ST_LOAD;
      end
    endcase
  end

  // Scan FSM state, counters, shadow word and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_LOAD;
      digit_r  <= {DIG_W{1'b0}};
      bit_r    <= 4'd0;
      phase_r  <= {PH_W{1'b0}};
      gap_r    <= {GAP_W{1'b0}};
      shadow_r <= 32'h0000_0000;
      vld_r    <= 1'b0;
      frame_r  <= {FRAME_W{1'b0}};
      ds_r     <= 1'b0;
      shclk_r  <= 1'b0;
      stclk_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      digit_r  <= digit_n;
      bit_r    <= bit_n;
      phase_r  <= phase_n;
      gap_r    <= gap_n;
      shadow_r <= shadow_n;
      vld_r    <= vld_n;
      frame_r  <= frame_n;
      ds_r     <= ds_n;
      shclk_r  <= shclk_n;
      stclk_r  <= stclk_n;
      busy_r   <= busy_n;
    end
  end

  assign bus.ds    = ds_r;
  assign bus.shclk = shclk_r;
  assign bus.stclk = stclk_r;
  assign bus.sel   = sel_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_seg_scan_sched.sv
// tb_seg_scan_sched: randomized scoreboard bench for seg_scan_sched.
// A reference process predicts every frame from the display rules (frame
// timing, per-round capture, blank/valid) and queues it; a monitor rebuilds
// frames from ds on shclk rises and checks each one on the stclk rise.
module tb_seg_scan_sched;

  localparam int NSRC = 4;
  localparam int DIV  = 2;
  localparam int GAP  = 4;
  localparam int DEB  = 4;
  localparam int FRAME_CYC = 1 + 32 * DIV + DIV + GAP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  seg_scan_sched_if #(.NSRC(NSRC)) bus ();

  seg_scan_sched #(.NSRC(NSRC), .DIV(DIV), .GAP(GAP), .DEB(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  logic [15:0] round_tab [8] = '{16'h8003, 16'h409F, 16'h2025, 16'h100D,
                                 16'h0899, 16'h0449, 16'h0241, 16'h011F};

  logic [15:0] exp_q [$];
  logic [15:0] got_log [$];
  int          m_cnt = 0;
  int          m_sel = 0;
  logic [31:0] m_word = 32'h0;
  logic        m_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic int next_valid(input int s, input logic [NSRC-1:0] v);
    for (int k = 1; k < NSRC; k++) begin
      if (v[(s + k) % NSRC]) return (s + k) % NSRC;
    end
    return s;
  endfunction

  function automatic logic [15:0] logged(input int idx);
    if (idx < got_log.size()) return got_log[idx];
    return 16'hxxxx;
  endfunction

  // Reference: a frame starts every FRAME_CYC cycles from reset release.
  initial begin : model
    int         dig;
    logic [7:0] sb;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_cnt  = 0;
        m_sel  = 0;
        m_word = 32'h0;
        m_vld  = 1'b0;
        exp_q.delete();
      end else begin
        if (m_cnt % FRAME_CYC == 0) begin
          dig = (m_cnt / FRAME_CYC) % 8;
          if (dig == 0) begin
            m_word = bus.src_data[32 * m_sel +: 32];
            m_vld  = bus.src_valid[m_sel];
          end
          sb = (bus.blank || !m_vld) ? 8'hFF : seg_tab[(m_word >> (4 * (7 - dig))) & 32'hF];
          exp_q.push_back({8'h80 >> dig, sb});
        end
        m_cnt++;
      end
    end
  end

  // Monitor: rebuild frames from the serial lines and score them.
  initial begin : monitor
    logic [15:0] shreg = 16'h0;
    int   nbits = 0, st_len = 0, cyc = 0, last_st = -1;
    logic prev_sh = 1'b0, prev_st = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        nbits = 0; st_len = 0; last_st = -1; prev_sh = 1'b0; prev_st = 1'b0;
      end else begin
        if (bus.shclk && !prev_sh) begin
          shreg = {shreg[14:0], bus.ds};
          nbits++;
        end
        if (bus.stclk) st_len++;
        if (bus.stclk && !prev_st) begin
          chk("shclk_rises", nbits, 16);
          chk("busy_in_latch", bus.busy, 1);
          if (last_st >= 0) chk("frame_period", cyc - last_st, FRAME_CYC);
          last_st = cyc;
          if (exp_q.size() == 0) fail_now("scoreboard_empty");
          else chk("frame", shreg, exp_q.pop_front());
          got_log.push_back(shreg);
          nbits = 0;
        end
        if (!bus.stclk && prev_st) begin
          chk("stclk_width", st_len, DIV);
          st_len = 0;
        end
        prev_sh = bus.shclk;
        prev_st = bus.stclk;
      end
    end
  end

  task automatic wait_frames(input int n);
    int target = got_log.size() + n;
    int guard  = 0;
    while (got_log.size() < target && guard < n * FRAME_CYC + 300) begin
      @(negedge clk);
      guard++;
    end
    if (got_log.size() < target) fail_now("frame_timeout");
  endtask

  // Key press of len cycles, started early in the given digit's frame.
  task automatic press(input int len, input int at_digit);
    int guard = 0;
    while (!((m_cnt % FRAME_CYC == 10) && ((m_cnt / FRAME_CYC) % 8 == at_digit))
           && guard < 9 * FRAME_CYC) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 9 * FRAME_CYC) fail_now("press_window_timeout");
    if (len >= DEB) m_sel = next_valid(m_sel, bus.src_valid);
    bus.key_n = 1'b0;
    repeat (len) @(negedge clk);
    bus.key_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("sel_model", bus.sel, m_sel);
  endtask

  initial begin : stim
    int n0, j, guard;
    bus.src_data  = {$urandom(), $urandom(), $urandom(), 32'h0123_4567};
    bus.src_valid = 4'b0001;
    bus.blank     = 1'b0;
    bus.key_n     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ds", bus.ds, 0);
    chk("rst_shclk", bus.shclk, 0);
    chk("rst_stclk", bus.stclk, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    // Basic frame and full round, frame 9 repeats digit 0.
    wait_frames(9);
    for (int i = 0; i < 9; i++) chk("round_frame", logged(i), round_tab[i % 8]);

    // Round-robin skip of invalid sources, and a glitch that is ignored.
    bus.src_valid = 4'b0101;
    press(8, 2);
    chk("rr_first", bus.sel, 2);
    press(8, 4);
    chk("rr_second", bus.sel, 0);
    press(3, 5);
    chk("rr_glitch", bus.sel, 0);

    // Mid-round press: this round stays on src0, next round shows src2.
    bus.src_data[95:64] = 32'hFFFF_FFFF;
    press(8, 3);
    chk("mid_sel", bus.sel, 2);
    n0 = got_log.size();
    wait_frames(6);
    for (int k = 0; k < 5; k++) chk("mid_keep_src0", logged(n0 + k), round_tab[3 + k]);
    chk("mid_next_round", logged(n0 + 5), 16'h8071);

    // Blank forces every segment byte off.
    @(negedge clk);
    bus.blank = 1'b1;
    n0 = got_log.size();
    wait_frames(9);
    for (int k = 1; k <= 8; k++) chk("blank_seg", logged(n0 + k) & 16'h00FF, 16'h00FF);
    bus.blank = 1'b0;

    // Selected source drops valid: the next full round is blank, sel stays.
    bus.src_valid = 4'b0001;
    n0 = got_log.size();
    wait_frames(17);
    j = n0 + 1;
    while (j < n0 + 9 && logged(j)[15:8] != 8'h80) j++;
    for (int k = 0; k < 8; k++) chk("invalid_seg", logged(j + k) & 16'h00FF, 16'h00FF);
    chk("invalid_sel_kept", bus.sel, 2);

    // Randomized rounds: data, valids, blank and key pulse lengths.
    for (int r = 0; r < 6; r++) begin
      bus.src_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.src_valid = 4'($urandom_range(0, 15));
      bus.blank     = ($urandom_range(0, 3) == 0);
      press($urandom_range(1, 10), $urandom_range(1, 5));
      bus.src_data[31:0] = $urandom();
      wait_frames(3);
    end
    bus.blank = 1'b0;
    bus.src_valid = 4'b1111;

    // Reset in the middle of bit 7 of a frame.
    guard = 0;
    while (bus.busy && guard < 2 * FRAME_CYC) begin @(negedge clk); guard++; end
    while (!bus.busy && guard < 2 * FRAME_CYC) begin @(negedge clk); guard++; end
    if (guard >= 2 * FRAME_CYC) fail_now("busy_timeout");
    repeat (33) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ds", bus.ds, 0);
    chk("midrst_shclk", bus.shclk, 0);
    chk("midrst_stclk", bus.stclk, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_sel", bus.sel, 0);
    m_sel = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n0 = got_log.size();
    wait_frames(2);
    chk("post_rst_digit0", logged(n0) & 16'hFF00, 16'h8000);
    chk("post_rst_digit1", logged(n0 + 1) & 16'hFF00, 16'h4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
